alu_issue_unit: RTL and testbench
=================================

ALU_ISSUE_UNIT -- requirements
Module: alu_issue_unit

Interface
REQ-001 Parameter: REG_COUNT, 8, number of 32-bit general registers; r0 is hardwired zero.
REQ-002 Parameter: REG_ADDR_W, 3, register index width; log2(REG_COUNT).
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-005 Port: instr_valid  in  1  instruction offered.
REQ-006 Port: instr_ready  out  1  unit can accept an instruction this cycle.
REQ-007 Port: instr_op  in  2  00 add, 01 sub, 10 xor, 11 slt.
REQ-008 Port: instr_rs1, instr_rs2, instr_rd  in  REG_ADDR_W each  source A, source B, destination.
REQ-009 Port: load_valid  in  1  direct register write request.
REQ-010 Port: load_addr  in  REG_ADDR_W; load_data  in  32  direct-write target and value.
REQ-011 Port: busA, busB  out  32 each  registered operands to the external ALU.
REQ-012 Port: ALUControl  out  2  registered op code to the external ALU.
REQ-013 Port: alu_out  in  32; alu_overflow, alu_negative, alu_zero  in  1 each  combinational ALU result and flags.
REQ-014 Port: flags  out  3  {overflow, negative, zero} of last completed instruction.
REQ-015 Port: done  out  1  high for exactly one cycle per completed instruction.
REQ-016 Port: dbg_addr  in  REG_ADDR_W; dbg_data  out  32  combinational register read; dbg_addr 0 returns 0.

Function
REQ-017 FSM states SHALL be IDLE, EXEC, WB; instr_ready SHALL be 1 only in IDLE with load_valid low.
REQ-018 In IDLE, load_valid SHALL write load_data to register load_addr at the clock edge; load_addr 0 SHALL be ignored.
REQ-019 load_valid and instr_valid both high in IDLE: load performed, instruction not accepted (instr_ready 0) that cycle.
REQ-020 load_valid outside IDLE SHALL be ignored (no write).
REQ-021 Accept edge (IDLE, instr_valid and instr_ready): busA <= reg[rs1], busB <= reg[rs2], ALUControl <= instr_op, rd latched, state -> EXEC.
REQ-022 Operand read SHALL return 0 for index 0 and current register contents otherwise (no write in flight in IDLE).
REQ-023 EXEC: at the next edge alu_out and the three ALU flags SHALL be captured into internal result registers; state -> WB.
REQ-024 WB: done = 1; at the closing edge reg[rd] <= captured result (dropped if rd = 0), flags <= captured flags (updated even if rd = 0); state -> IDLE.
REQ-025 Latency: accept at edge N, EXEC during cycle N..N+1, WB during N+1..N+2, instr_ready high again after edge N+2; maximum throughput one instruction per 3 cycles.
REQ-026 busA, busB, ALUControl SHALL hold their values outside the accept edge.
REQ-027 A following instruction reading rd SHALL observe the written value (no hazard possible by construction).
REQ-028 instr_op, rs1, rs2, rd SHALL be sampled only at the accept edge; changes afterward have no effect.
REQ-029 done SHALL be 0 in IDLE and EXEC.

Reset
REQ-030 rst_n low SHALL immediately force: state IDLE, all registers 0, busA 0, busB 0, ALUControl 00, flags 000, done 0.
REQ-031 Reset during EXEC or WB SHALL abandon the instruction: no register or flag write, no done pulse.
REQ-032 First cycle after rst_n deasserts: instr_ready = 1 (if load_valid low).

Verification
REQ-033 Load r1=5, r2=3; add rd=r3 -> busA=5, busB=3, ALUControl=00 in EXEC; done one cycle; r3=8; flags=000; instr_ready back 3 cycles after accept.
REQ-034 Load r1=0x1234; sub r1,r1 -> r4 -> r4=0, flags=001.
REQ-035 Load r1=0x7FFFFFFF, r2=1; add -> r5 -> r5=0x80000000, flags=110.
REQ-036 Add r1,r2 -> rd=0 -> dbg_data at addr 0 reads 0; flags still updated; load to addr 0 also ignored.
REQ-037 Assert rst_n low during EXEC -> no done pulse, all registers and flags read 0, instr_ready 1 after release.
REQ-038 load_valid and instr_valid high same IDLE cycle -> load written, instr_ready 0 that cycle, instruction accepted next cycle using the newly loaded value.

Source files
------------

// File: rtl/alu_issue_unit.sv
// ALU issue unit: small register file, operand staging for an external ALU,
// and a three-state IDLE/EXEC/WB sequencer with result writeback.
module alu_issue_unit #(
  parameter int REG_COUNT  = 8,
  parameter int REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [1:0]            instr_op,
  input  logic [REG_ADDR_W-1:0] instr_rs1,
  input  logic [REG_ADDR_W-1:0] instr_rs2,
  input  logic [REG_ADDR_W-1:0] instr_rd,
  input  logic                  load_valid,
  input  logic [REG_ADDR_W-1:0] load_addr,
  input  logic [31:0]           load_data,
  output logic [31:0]           busA,
  output logic [31:0]           busB,
  output logic [1:0]            ALUControl,
  input  logic [31:0]           alu_out,
  input  logic                  alu_overflow,
  input  logic                  alu_negative,
  input  logic                  alu_zero,
  output logic [2:0]            flags,
  output logic                  done,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic [31:0]           dbg_data
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WB
  } state_t;

  state_t state, state_nx;

  logic [31:0]           regs [REG_COUNT];
  logic [REG_ADDR_W-1:0] rd_q;
  logic [31:0]           res_q;
  logic [2:0]            rflg_q;

  logic accept;
  logic load_we;
  logic wb_we;

  function automatic logic [31:0] rdreg(
    input logic [REG_ADDR_W-1:0] idx
  );
    rdreg = (idx == '0) ? 32'd0 : regs[idx];
  endfunction

  assign instr_ready = (state == IDLE) && !load_valid;
  assign accept      = instr_valid && instr_ready;
  assign load_we     = (state == IDLE) && load_valid && (load_addr != '0);
  assign wb_we       = (state == WB) && (rd_q != '0);
  assign done        = (state == WB);
  assign dbg_data    = rdreg(dbg_addr);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = EXEC;
      EXEC:    state_nx = WB;
      WB:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // loads only happen in IDLE and writeback only in WB, so they never collide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= 32'd0;
    end else begin
      for (int i = 1; i < REG_COUNT; i++) begin
        if (load_we && load_addr == REG_ADDR_W'(i))
          regs[i] <= load_data;
        else if (wb_we && rd_q == REG_ADDR_W'(i))
          regs[i] <= res_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busA       <= 32'd0;
      busB       <= 32'd0;
      ALUControl <= 2'b00;
      rd_q       <= '0;
    end else if (accept) begin
      busA       <= rdreg(instr_rs1);
      busB       <= rdreg(instr_rs2);
      ALUControl <= instr_op;
      rd_q       <= instr_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q  <= 32'd0;
      rflg_q <= 3'b000;
    end else if (state == EXEC) begin
      res_q  <= alu_out;
      rflg_q <= {alu_overflow, alu_negative, alu_zero};
    end
  end

  // flags track every completed instruction, including rd = r0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           flags <= 3'b000;
    else if (state == WB) flags <= rflg_q;
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: behavioural external ALU, a directed
// instruction table and hand sequences for load/issue/reset corners.
module tb_alu_issue_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [1:0]  instr_op;
  logic [2:0]  instr_rs1, instr_rs2, instr_rd;
  logic        load_valid;
  logic [2:0]  load_addr;
  logic [31:0] load_data;
  logic [31:0] busA, busB;
  logic [1:0]  ALUControl;
  logic [31:0] alu_out;
  logic        alu_overflow, alu_negative, alu_zero;
  logic [2:0]  flags;
  logic        done;
  logic [2:0]  dbg_addr;
  logic [31:0] dbg_data;

  alu_issue_unit #(.REG_COUNT(8), .REG_ADDR_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rs1(instr_rs1),
    .instr_rs2(instr_rs2), .instr_rd(instr_rd),
    .load_valid(load_valid), .load_addr(load_addr),
    .load_data(load_data),
    .busA(busA), .busB(busB), .ALUControl(ALUControl),
    .alu_out(alu_out), .alu_overflow(alu_overflow),
    .alu_negative(alu_negative), .alu_zero(alu_zero),
    .flags(flags), .done(done),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // external ALU model
  always_comb begin
    logic [31:0] r;
    logic        ov;
    r  = 32'd0;
    ov = 1'b0;
    case (ALUControl)
      2'b00: begin
        r  = busA + busB;
        ov = (busA[31] == busB[31]) && (r[31] != busA[31]);
      end
      2'b01: begin
        r  = busA - busB;
        ov = (busA[31] != busB[31]) && (r[31] != busA[31]);
      end
      2'b10: r = busA ^ busB;
      default: r = ($signed(busA) < $signed(busB)) ? 32'd1 : 32'd0;
    endcase
    alu_out      = r;
    alu_overflow = ov;
    alu_negative = r[31];
    alu_zero     = (r == 32'd0);
  end

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  rs1, rs2, rd;
    logic [31:0] res;
    logic [2:0]  flg;
  } vec_t;

  vec_t        vt [10];
  logic [31:0] mdl [8];
  int          ncmp = 0;
  int          nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic rd_chk(input string nm, input logic [2:0] a,
                        input logic [31:0] exp);
    dbg_addr = a;
    #1;
    chk(nm, dbg_data, exp);
  endtask

  task automatic do_load(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    load_valid = 1'b1;
    load_addr  = a;
    load_data  = d;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    if (a != 3'd0) mdl[a] = d;
  endtask

  task automatic issue(input logic [1:0] op, input logic [2:0] a,
                       input logic [2:0] b, input logic [2:0] d,
                       input logic [31:0] res, input logic [2:0] flg);
    @(negedge clk);
    chk("ready_idle", instr_ready, 1);
    instr_valid = 1'b1;
    instr_op    = op;
    instr_rs1   = a;
    instr_rs2   = b;
    instr_rd    = d;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr_op    = ~op;
    instr_rs1   = ~a;
    instr_rs2   = ~b;
    instr_rd    = ~d;
    @(negedge clk);
    chk("exec_busA", busA, mdl[a]);
    chk("exec_busB", busB, mdl[b]);
    chk("exec_ctl", ALUControl, op);
    chk("exec_done", done, 0);
    chk("exec_ready", instr_ready, 0);
    load_valid = 1'b1;
    load_addr  = 3'd7;
    load_data  = 32'hBAD0BAD0;
    @(negedge clk);
    chk("wb_done", done, 1);
    chk("wb_ready", instr_ready, 0);
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    @(negedge clk);
    chk("idle_done", done, 0);
    chk("idle_ready", instr_ready, 1);
    chk("flags", flags, flg);
    rd_chk("rd_val", d, (d == 3'd0) ? 32'd0 : res);
    rd_chk("r7_kept", 3'd7, mdl[7]);
    if (d != 3'd0) mdl[d] = res;
  endtask

  initial begin
    vt[0] = '{2'b00, 3'd1, 3'd2, 3'd3, 32'd8,          3'b000};
    vt[1] = '{2'b01, 3'd2, 3'd1, 3'd4, 32'hFFFFFFFE,   3'b010};
    vt[2] = '{2'b10, 3'd1, 3'd2, 3'd5, 32'd6,          3'b000};
    vt[3] = '{2'b11, 3'd2, 3'd1, 3'd3, 32'd1,          3'b000};
    vt[4] = '{2'b11, 3'd1, 3'd2, 3'd3, 32'd0,          3'b001};
    vt[5] = '{2'b00, 3'd6, 3'd7, 3'd5, 32'h80000000,   3'b110};
    vt[6] = '{2'b01, 3'd1, 3'd1, 3'd4, 32'd0,          3'b001};
    vt[7] = '{2'b00, 3'd1, 3'd2, 3'd0, 32'd8,          3'b000};
    vt[8] = '{2'b01, 3'd0, 3'd7, 3'd3, 32'hFFFFFFFF,   3'b010};
    vt[9] = '{2'b11, 3'd5, 3'd1, 3'd4, 32'd1,          3'b000};
    for (int i = 0; i < 8; i++) mdl[i] = 32'd0;

    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr_op    = 2'b00;
    instr_rs1   = 3'd0;
    instr_rs2   = 3'd0;
    instr_rd    = 3'd0;
    load_valid  = 1'b0;
    load_addr   = 3'd0;
    load_data   = 32'd0;
    dbg_addr    = 3'd0;

    @(negedge clk);
    chk("rst_ready", instr_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_busA", busA, 0);
    chk("rst_busB", busB, 0);
    chk("rst_ctl", ALUControl, 0);
    chk("rst_flags", flags, 0);
    rd_chk("rst_r1", 3'd1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", instr_ready, 1);

    do_load(3'd1, 32'd5);
    do_load(3'd2, 32'd3);
    do_load(3'd6, 32'h7FFFFFFF);
    do_load(3'd7, 32'd1);
    do_load(3'd0, 32'hDEADBEEF);
    @(negedge clk);
    rd_chk("load_r0", 3'd0, 0);
    rd_chk("load_r1", 3'd1, 32'd5);

    for (int i = 0; i < 10; i++)
      issue(vt[i].op, vt[i].rs1, vt[i].rs2, vt[i].rd,
            vt[i].res, vt[i].flg);

    do_load(3'd1, 32'h00001234);
    issue(2'b01, 3'd1, 3'd1, 3'd4, 32'd0, 3'b001);

    // load and instruction offered together
    @(negedge clk);
    load_valid  = 1'b1;
    load_addr   = 3'd1;
    load_data   = 32'd9;
    instr_valid = 1'b1;
    instr_op    = 2'b00;
    instr_rs1   = 3'd1;
    instr_rs2   = 3'd2;
    instr_rd    = 3'd3;
    #1;
    chk("both_ready", instr_ready, 0);
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    mdl[1]     = 32'd9;
    @(negedge clk);
    chk("both_ready2", instr_ready, 1);
    rd_chk("both_r1", 3'd1, 32'd9);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(negedge clk);
    chk("both_busA", busA, 32'd9);
    chk("both_busB", busB, 32'd3);
    @(negedge clk);
    chk("both_done", done, 1);
    @(negedge clk);
    rd_chk("both_r3", 3'd3, 32'd12);
    chk("both_flags", flags, 0);
    mdl[3] = 32'd12;

    // reset while in EXEC, after a result with nonzero flags
    issue(2'b01, 3'd2, 3'd1, 3'd4, 32'hFFFFFFFA, 3'b010);
    @(negedge clk);
    instr_valid = 1'b1;
    instr_op    = 2'b00;
    instr_rs1   = 3'd1;
    instr_rs2   = 3'd2;
    instr_rd    = 3'd3;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_done", done, 0);
    chk("mid_rst_flags", flags, 0);
    chk("mid_rst_busA", busA, 0);
    chk("mid_rst_ready", instr_ready, 1);
    rd_chk("mid_rst_r1", 3'd1, 0);
    rd_chk("mid_rst_r4", 3'd4, 0);
    @(negedge clk);
    chk("mid_rst_done2", done, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) mdl[i] = 32'd0;
    @(negedge clk);
    chk("rel_ready", instr_ready, 1);
    chk("rel_done", done, 0);
    rd_chk("rel_r3", 3'd3, 0);

    do_load(3'd1, 32'd2);
    do_load(3'd2, 32'd2);
    issue(2'b00, 3'd1, 3'd2, 3'd3, 32'd4, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
